// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM read/write stream masters: FSM encoding,
// read-latency constants and the address-width helper.
package bram_pkg;

    localparam int LAT_LOW  = 1;
    localparam int LAT_HIGH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Bits needed to represent 'depth' (clogb2(1023) = 10, clogb2(4) = 3).
    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        r = 0;
        while (d > 0) begin
            r++;
            d = d >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// First-word fall-through FIFO with a push-to-head bypass when empty, so a word
// arriving into an empty FIFO is visible (and poppable) in the same cycle.
module stream_skid_fifo
    import bram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = clogb2(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? clogb2(DEPTH - 1) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] head_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] count_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, bypass, do_pop, store, take;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNT_W'(DEPTH));
        bypass    = empty && push_in;
        valid_out = !empty || push_in;
        head_out  = bypass ? push_data_in : mem_q[rd_ptr_q];
        do_pop    = pop_in && valid_out;
        // A bypassed word that is popped immediately never touches storage.
        store     = push_in && (!full || do_pop) && !(bypass && do_pop);
        take      = do_pop && !bypass;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            mem_d[wr_ptr_q] = push_data_in;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (take) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({store, take})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side BRAM master: issues length consecutive reads under a credit limit and
// streams the returned words out through a skid FIFO with valid/ready.
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int READ_LATENCY = LAT_HIGH,
    parameter int FIFO_DEPTH   = 4,
    localparam int ADDR_W = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [ADDR_W-1:0]    base_addr_in,
    input  logic [ADDR_W:0]      length_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [ADDR_W-1:0]    ram_addr_out,
    output logic                 ram_en_out,
    output logic                 ram_we_out,
    output logic                 ram_regce_out,
    output logic                 ram_rst_out,
    input  logic [RAM_WIDTH-1:0] ram_dout_in,
    output logic [RAM_WIDTH-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 last_out
);

    localparam int CNT_W = clogb2(FIFO_DEPTH);

    generate
        if (READ_LATENCY < 1 || FIFO_DEPTH < READ_LATENCY + 1) begin : g_bad_cfg
            $error("bram_stream_reader: FIFO_DEPTH must be >= READ_LATENCY+1");
        end
    endgenerate

    rd_state_e               state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         len_q, len_d;
    logic [ADDR_W:0]         issued_q, issued_d;
    logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
    logic                    done_q, done_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight, credit_sum;
    logic             issue, issue_last, pop, last_beat;
    logic [RAM_WIDTH:0] fifo_head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + {{CNT_W{1'b0}}, vld_pipe_q[i]};
        end
        // Credit uses registered counts only, so ready_in never reaches ram_en_out.
        credit_sum = {1'b0, fifo_count} + inflight;
        issue      = (state_q == ISSUE) && (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
        issue_last = issue && (issued_q == len_q - (ADDR_W + 1)'(1));
        pop        = valid_out && ready_in;
        last_beat  = pop && fifo_head[RAM_WIDTH];

        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        done_d      = 1'b0;
        vld_pipe_d  = vld_pipe_q << 1;
        last_pipe_d = last_pipe_q << 1;
        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue_last;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (length_in != '0) begin
                        state_d  = ISSUE;
                        addr_d   = base_addr_in;
                        len_d    = length_in;
                        issued_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d   = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                    issued_d = issued_q + (ADDR_W + 1)'(1);
                    if (issue_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            done_q      <= done_d;
        end
    end

    stream_skid_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_in      (vld_pipe_q[READ_LATENCY-1]),
        .push_data_in ({last_pipe_q[READ_LATENCY-1], ram_dout_in}),
        .pop_in       (pop),
        .head_out     (fifo_head),
        .valid_out    (valid_out),
        .count_out    (fifo_count)
    );

    assign data_out      = fifo_head[RAM_WIDTH-1:0];
    assign last_out      = valid_out && fifo_head[RAM_WIDTH];
    assign busy_out      = (state_q != IDLE);
    assign done_out      = done_q;
    assign ram_en_out    = issue;
    assign ram_addr_out  = addr_q;
    assign ram_we_out    = 1'b0;
    assign ram_regce_out = 1'b1;
    assign ram_rst_out   = 1'b0;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a 2-cycle HIGH_PERFORMANCE BRAM model
// preloaded with mem[i] = i ^ 18'h155; a negedge monitor scoreboards every beat.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic [9:0]  base_addr_in = '0;
    logic [10:0] length_in = '0;
    logic        busy_out, done_out, ram_en_out, ram_we_out, ram_regce_out, ram_rst_out;
    logic [9:0]  ram_addr_out;
    logic [17:0] ram_dout_in, data_out;
    logic        valid_out, last_out;
    logic        ready_in = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issued = 0, popped = 0, done_cnt = 0, done_cyc = 0;
    int sb_base = 0, sb_len = 0, sb_idx = 0;
    int en_addrs[$];
    int beat_cyc[$];

    bram_stream_reader #(
        .RAM_WIDTH(18), .RAM_DEPTH(1024), .READ_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start_in), .base_addr_in(base_addr_in),
        .length_in(length_in), .busy_out(busy_out), .done_out(done_out),
        .ram_addr_out(ram_addr_out), .ram_en_out(ram_en_out), .ram_we_out(ram_we_out),
        .ram_regce_out(ram_regce_out), .ram_rst_out(ram_rst_out), .ram_dout_in(ram_dout_in),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM read port, HIGH_PERFORMANCE: array read register then output register
    logic [17:0] ram_mem [1024];
    logic [17:0] ram_data = '0;
    logic [17:0] ram_dout = '0;
    initial for (int i = 0; i < 1024; i++) ram_mem[i] = 18'(i) ^ 18'h155;
    always @(posedge clk) begin
        if (ram_en_out && !ram_we_out) ram_data <= ram_mem[ram_addr_out];
        if (ram_rst_out) ram_dout <= '0;
        else if (ram_regce_out) ram_dout <= ram_data;
    end
    assign ram_dout_in = ram_dout;

    always @(negedge clk) begin
        if (rst) begin
            issued = 0; popped = 0; done_cnt = 0; sb_idx = 0;
        end else begin
            checks++;
            if (ram_we_out !== 1'b0 || ram_regce_out !== 1'b1 || ram_rst_out !== 1'b0) begin
                failures++;
                $display("FAIL ram_ties we=%b regce=%b rst=%b required 0/1/0", ram_we_out, ram_regce_out, ram_rst_out);
            end
            if (ram_en_out) begin issued++; en_addrs.push_back(int'(ram_addr_out)); end
            if (valid_out && ready_in) begin
                checks++;
                if (sb_idx >= sb_len) begin
                    failures++;
                    $display("FAIL extra_beat idx=%0d len=%0d data=%h", sb_idx, sb_len, data_out);
                end else if (data_out !== ram_mem[(sb_base + sb_idx) % 1024] || last_out !== (sb_idx == sb_len - 1)) begin
                    failures++;
                    $display("FAIL beat_%0d data=%h last=%b required data=%h last=%b", sb_idx, data_out, last_out,
                             ram_mem[(sb_base + sb_idx) % 1024], (sb_idx == sb_len - 1));
                end
                sb_idx++; popped++; beat_cyc.push_back(cyc);
            end
            checks++;
            if (issued - popped > 4) begin
                failures++;
                $display("FAIL credit outstanding=%0d required<=4", issued - popped);
            end
            if (done_out) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic pulse_start(input int base, input int len);
        @(posedge clk); #1;
        sb_base = base; sb_len = len; sb_idx = 0;
        en_addrs.delete(); beat_cyc.delete();
        base_addr_in = 10'(base); length_in = 11'(len); start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > d0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_out, done_out, valid_out, last_out, ram_en_out} !== 5'b0 || ram_addr_out !== '0 || data_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs flags=%b addr=%0d data=%h required all 0",
                     {busy_out, done_out, valid_out, last_out, ram_en_out}, ram_addr_out, data_out);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic;
        int d0, lat;
        bit ok;
        ready_in = 1'b1;
        d0 = done_cnt;
        pulse_start(0, 8);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (valid_out) break;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL first_valid_latency got=%0d required=3", lat); end
        wait_done(d0, 100, ok);
        checks++;
        if (!ok || sb_idx != 8) begin failures++; $display("FAIL basic_count done=%b beats=%0d required 8", ok, sb_idx); end
        checks++;
        if (beat_cyc.size() != 8 || beat_cyc[7] - beat_cyc[0] != 7) begin
            failures++; $display("FAIL basic_back_to_back beats=%0d span=%0d required 8/7", beat_cyc.size(),
                                 beat_cyc.size() == 8 ? beat_cyc[7] - beat_cyc[0] : -1);
        end
        checks++;
        if (beat_cyc.size() != 8 || done_cyc != beat_cyc[7] + 1) begin
            failures++; $display("FAIL basic_done_timing done_cyc=%0d required last_beat+1", done_cyc);
        end
    endtask

    task automatic test_wrap;
        int d0;
        bit ok;
        d0 = done_cnt;
        pulse_start(1020, 8);
        wait_done(d0, 100, ok);
        checks++;
        if (!ok || sb_idx != 8 || en_addrs.size() != 8) begin
            failures++; $display("FAIL wrap_count done=%b beats=%0d reads=%0d required 8", ok, sb_idx, en_addrs.size());
        end
        for (int i = 0; i < 8 && i < en_addrs.size(); i++) begin
            checks++;
            if (en_addrs[i] != (1020 + i) % 1024) begin
                failures++; $display("FAIL wrap_addr_%0d got=%0d required=%0d", i, en_addrs[i], (1020 + i) % 1024);
            end
        end
    endtask

    task automatic test_random_ready;
        int d0;
        bit ok;
        d0 = done_cnt;
        pulse_start(100, 64);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ready_in = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            if (done_cnt > d0) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        ready_in = 1'b1;
        checks++;
        if (!ok || sb_idx != 64 || beat_cyc.size() != 64) begin
            failures++; $display("FAIL random_ready done=%b beats=%0d required 64", ok, sb_idx);
        end
    endtask

    task automatic test_backpressure;
        int d0, i0;
        logic [17:0] d_early;
        bit ok;
        ready_in = 1'b0;
        d0 = done_cnt; i0 = issued;
        pulse_start(200, 12);
        repeat (5) @(negedge clk);
        d_early = data_out;
        repeat (15) @(negedge clk);
        checks++;
        if (issued - i0 != 4) begin failures++; $display("FAIL bp_issued got=%0d required=4", issued - i0); end
        checks++;
        if (valid_out !== 1'b1 || data_out !== d_early || data_out !== (18'd200 ^ 18'h155)) begin
            failures++; $display("FAIL bp_hold valid=%b data=%h early=%h required 1/%h", valid_out, data_out, d_early, 18'd200 ^ 18'h155);
        end
        @(posedge clk); #1 ready_in = 1'b1;
        wait_done(d0, 100, ok);
        checks++;
        if (!ok || sb_idx != 12 || issued - i0 != 12) begin
            failures++; $display("FAIL bp_resume done=%b beats=%0d reads=%0d required 12", ok, sb_idx, issued - i0);
        end
    endtask

    task automatic test_zero_and_ignore;
        int d0, i0;
        bit ok;
        d0 = done_cnt;
        pulse_start(5, 0);
        @(negedge clk);
        checks++;
        if (done_out !== 1'b1 || busy_out !== 1'b0 || valid_out !== 1'b0) begin
            failures++; $display("FAIL zero_len done=%b busy=%b valid=%b required 1/0/0", done_out, busy_out, valid_out);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || sb_idx != 0) begin
            failures++; $display("FAIL zero_len_pulses dones=%0d beats=%0d required 1/0", done_cnt - d0, sb_idx);
        end
        d0 = done_cnt; i0 = issued;
        pulse_start(300, 16);
        @(negedge clk);
        checks++;
        if (busy_out !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b required=1", busy_out); end
        @(posedge clk); #1;
        base_addr_in = 10'd0; length_in = 11'd4; start_in = 1'b1;
        @(posedge clk); #1 start_in = 1'b0;
        wait_done(d0, 100, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || sb_idx != 16 || done_cnt - d0 != 1 || issued - i0 != 16 || busy_out !== 1'b0) begin
            failures++; $display("FAIL ignore_start done=%b beats=%0d dones=%0d reads=%0d busy=%b required 16/1/16/0",
                                 ok, sb_idx, done_cnt - d0, issued - i0, busy_out);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        bit ok;
        ready_in = 1'b1;
        pulse_start(0, 32);
        n = 0;
        while (popped < 5 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy_out, done_out, valid_out, last_out, ram_en_out} !== 5'b0 || ram_addr_out !== '0 || data_out !== '0) begin
            failures++; $display("FAIL mid_reset flags=%b addr=%0d data=%h required all 0",
                                 {busy_out, done_out, valid_out, last_out, ram_en_out}, ram_addr_out, data_out);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != 0 || valid_out !== 1'b0) begin
            failures++; $display("FAIL mid_reset_quiet dones=%0d valid=%b required 0/0", done_cnt, valid_out);
        end
        pulse_start(0, 4);
        wait_done(0, 100, ok);
        checks++;
        if (!ok || sb_idx != 4) begin
            failures++; $display("FAIL post_reset_xfer done=%b beats=%0d required 4", ok, sb_idx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_random_ready();
        test_backpressure();
        test_zero_and_ignore();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
